// File: rtl/axis_header_insert_arbiter_pkg.sv
// Shared definitions for the header-insert arbiter.
// Contents:
//   state_t  - FSM state encoding (ST_IDLE, ST_HDR, ST_PAY)
//   rr_next  - round-robin index increment that wraps at n-1 back to 0
package axis_hdr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  // Next round-robin index after idx, wrapping at n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    int nxt;
    if (idx + 32'sd1 >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = idx + 32'sd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axis_header_insert_arbiter_if.sv
// Bundle of the per-source header/payload AXI-Stream channels and the single
// downstream channel pair feeding the insertion datapath.
// Modports:
//   slave  - the arbiter's view: source channels in, datapath channels out
//   master - the environment's view: drives sources, sinks the datapath
// Source i occupies slice [i*DATA_WD +: DATA_WD] (data) and
// [i*DATA_BYTE_WD +: DATA_BYTE_WD] (keep) of the packed vectors.
interface axis_hdr_arb_if #(
  parameter int N_SRC        = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic [N_SRC-1:0]              s_valid_insert;
  logic [N_SRC*DATA_WD-1:0]      s_header_insert;
  logic [N_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [N_SRC-1:0]              s_ready_insert;
  logic [N_SRC-1:0]              s_valid_in;
  logic [N_SRC*DATA_WD-1:0]      s_data_in;
  logic [N_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [N_SRC-1:0]              s_last_in;
  logic [N_SRC-1:0]              s_ready_in;
  logic                          m_valid_insert;
  logic [DATA_WD-1:0]            m_header_insert;
  logic [DATA_BYTE_WD-1:0]       m_keep_insert;
  logic                          m_ready_insert;
  logic                          m_valid_in;
  logic [DATA_WD-1:0]            m_data_in;
  logic [DATA_BYTE_WD-1:0]       m_keep_in;
  logic                          m_last_in;
  logic                          m_ready_in;

  modport slave (
    input  s_valid_insert, s_header_insert, s_keep_insert,
    output s_ready_insert,
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_ready_in,
    output m_valid_insert, m_header_insert, m_keep_insert,
    input  m_ready_insert,
    output m_valid_in, m_data_in, m_keep_in, m_last_in,
    input  m_ready_in
  );

  modport master (
    output s_valid_insert, s_header_insert, s_keep_insert,
    input  s_ready_insert,
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_ready_in,
    input  m_valid_insert, m_header_insert, m_keep_insert,
    output m_ready_insert,
    input  m_valid_in, m_data_in, m_keep_in, m_last_in,
    output m_ready_in
  );
endinterface

// File: rtl/axis_header_insert_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       in  N_SRC   request vector
//   rr_ptr    in  SRC_WD  highest-priority index for this pick
//   gnt_valid out 1       at least one request present
//   gnt_idx   out SRC_WD  first set req bit at or above rr_ptr, with wrap
module rr_arbiter #(
  parameter int N_SRC  = 4,
  parameter int SRC_WD = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]  req,
  input  logic [SRC_WD-1:0] rr_ptr,
  output logic              gnt_valid,
  output logic [SRC_WD-1:0] gnt_idx
);

  logic [31:0]       pos_s;
  logic [SRC_WD-1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos_s     = 32'd0;
    cand_s    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pos_s = 32'(rr_ptr) + 32'(k);
      if (pos_s >= 32'(N_SRC)) begin
        pos_s = pos_s - 32'(N_SRC);
      end else begin
        pos_s = pos_s;
      end
      cand_s = SRC_WD'(pos_s);
      if (req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_idx   = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/axis_header_insert_arbiter.sv
// Round-robin arbiter sharing one header-insertion datapath among N_SRC
// requesters. A granted source sends its header, then its whole payload
// packet; the grant is released only when the last payload beat is accepted.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         source header/payload channels in, datapath channels out
//   grant_id    currently (or most recently) granted source
//   busy        high while a grant is active (HDR or PAY)
//   pkt_done    one-cycle pulse after the last payload beat is accepted
module axis_header_insert_arbiter
  import axis_hdr_arb_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int N_SRC        = 4,
  parameter int SRC_WD       = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  axis_hdr_arb_if.slave     bus,
  output logic [SRC_WD-1:0] grant_id,
  output logic              busy,
  output logic              pkt_done
);

  state_t            state_r, state_nxt_s;
  logic [SRC_WD-1:0] rr_ptr_r, rr_ptr_nxt_s, grant_nxt_s;
  logic              done_nxt_s;
  logic              gnt_valid_s;
  logic [SRC_WD-1:0] gnt_idx_s;
  logic              hdr_fire_s, last_fire_s;

  rr_arbiter #(.N_SRC(N_SRC), .SRC_WD(SRC_WD)) u_rr (
    .req      (bus.s_valid_insert),
    .rr_ptr   (rr_ptr_r),
    .gnt_valid(gnt_valid_s),
    .gnt_idx  (gnt_idx_s)
  );

  assign busy = (state_r != ST_IDLE);

  // State, round-robin pointer, grant and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      grant_id <= '0;
      pkt_done <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_id <= grant_nxt_s;
      pkt_done <= done_nxt_s;
    end
  end

  // Next-state logic and the grant-steered forward/ready muxes.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    grant_nxt_s  = grant_id;
    done_nxt_s   = 1'b0;
    hdr_fire_s   = 1'b0;
    last_fire_s  = 1'b0;

    bus.s_ready_insert  = '0;
    bus.s_ready_in      = '0;
    bus.m_valid_insert  = 1'b0;
    bus.m_valid_in      = 1'b0;
    // Data paths always follow grant_id; only the valids are state-gated.
    bus.m_header_insert = bus.s_header_insert[32'(grant_id)*DATA_WD +: DATA_WD];
    bus.m_keep_insert   = bus.s_keep_insert[32'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
    bus.m_data_in       = bus.s_data_in[32'(grant_id)*DATA_WD +: DATA_WD];
    bus.m_keep_in       = bus.s_keep_in[32'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
    bus.m_last_in       = bus.s_last_in[grant_id];

    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          grant_nxt_s = gnt_idx_s;
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        bus.m_valid_insert           = bus.s_valid_insert[grant_id];
        bus.s_ready_insert[grant_id] = bus.m_ready_insert;
        hdr_fire_s = bus.s_valid_insert[grant_id] & bus.m_ready_insert;
        if (hdr_fire_s) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_PAY: begin
        bus.m_valid_in           = bus.s_valid_in[grant_id];
        bus.s_ready_in[grant_id] = bus.m_ready_in;
        last_fire_s = bus.s_valid_in[grant_id] & bus.m_ready_in & bus.s_last_in[grant_id];
        if (last_fire_s) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = SRC_WD'(rr_next(32'(grant_id), N_SRC));
          done_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_PAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_header_insert_arbiter.sv
// Self-checking bench for axis_header_insert_arbiter (N_SRC=4, DATA_WD=32).
// Sources are modelled as per-source header/beat queues; every pushed item is
// also pushed to an expected queue and popped when it emerges downstream.
module tb_axis_header_insert_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic          rst_first;
    logic [N-1:0]  mask;
    logic [7:0]    nbeats;
    logic [15:0]   ord;    // expected grant order, first grant in [15:12]
    logic [3:0]    n_ord;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [SW-1:0] grant_id;
  logic busy, pkt_done;

  axis_hdr_arb_if #(.N_SRC(N), .DATA_WD(DW), .DATA_BYTE_WD(KW)) bus ();

  axis_header_insert_arbiter #(
    .DATA_WD(DW), .DATA_BYTE_WD(KW), .N_SRC(N), .SRC_WD(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  beat_t hq[N][$];
  beat_t bq[N][$];
  beat_t ehq[N][$];
  beat_t ebq[N][$];
  int    got_q[$];
  logic [N-1:0] hacc = '0;
  logic [N-1:0] bacc = '0;
  logic hold_ins = 1'b0;
  logic toggle_in = 1'b0;
  logic exp_pd = 1'b0;
  int   pd_cnt = 0;
  int   tag = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int n, input logic [DW-1:0] hdr, input logic [KW-1:0] hkeep);
    beat_t b;
    b = '{hdr, hkeep, 1'b0};
    hq[s].push_back(b);
    ehq[s].push_back(b);
    for (int i = 0; i < n; i++) begin
      b.data = {8'(s), 8'(tag), 8'hB0, 8'(i)};
      b.keep = (i == n - 1) ? 4'h7 : 4'hF;
      b.last = (i == n - 1);
      bq[s].push_back(b);
      ebq[s].push_back(b);
    end
    tag++;
  endtask

  task automatic drive();
    logic [N-1:0]    vh, vb, lb;
    logic [N*DW-1:0] hd, bd;
    logic [N*KW-1:0] hk, bk;
    vh = '0; vb = '0; lb = '0; hd = '0; bd = '0; hk = '0; bk = '0;
    for (int s = 0; s < N; s++) begin
      if (hacc[s] && hq[s].size() > 0) void'(hq[s].pop_front());
      if (bacc[s] && bq[s].size() > 0) void'(bq[s].pop_front());
      if (hq[s].size() > 0) begin
        vh[s] = 1'b1;
        hd[s*DW +: DW] = hq[s][0].data;
        hk[s*KW +: KW] = hq[s][0].keep;
      end
      if (bq[s].size() > 0) begin
        vb[s] = 1'b1;
        bd[s*DW +: DW] = bq[s][0].data;
        bk[s*KW +: KW] = bq[s][0].keep;
        lb[s] = bq[s][0].last;
      end
    end
    hacc = '0;
    bacc = '0;
    bus.s_valid_insert  = vh;
    bus.s_header_insert = hd;
    bus.s_keep_insert   = hk;
    bus.s_valid_in      = vb;
    bus.s_data_in       = bd;
    bus.s_keep_in       = bk;
    bus.s_last_in       = lb;
    bus.m_ready_insert  = !hold_ins;
    bus.m_ready_in      = toggle_in ? !bus.m_ready_in : 1'b1;
  endtask

  task automatic monitor();
    int gid;
    beat_t e;
    logic [N-1:0] oh;
    logic leak;
    if (rst_n) begin
      gid  = int'(grant_id);
      hacc = bus.s_valid_insert & bus.s_ready_insert;
      bacc = bus.s_valid_in & bus.s_ready_in;
      if (pkt_done || exp_pd) chk("pkt_done", 64'(pkt_done), 64'(exp_pd));
      if (pkt_done) pd_cnt++;
      exp_pd = bus.m_valid_in && bus.m_ready_in && bus.m_last_in;
      if (bus.m_valid_insert && bus.m_ready_insert) begin
        got_q.push_back(gid);
        if (ehq[gid].size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_hdr actual=%0h required=none src=%0d", bus.m_header_insert, gid);
        end else begin
          e = ehq[gid].pop_front();
          chk("hdr_data", 64'(bus.m_header_insert), 64'(e.data));
          chk("hdr_keep", 64'(bus.m_keep_insert), 64'(e.keep));
        end
      end
      if (bus.m_valid_in && bus.m_ready_in) begin
        if (ebq[gid].size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=%0h required=none src=%0d", bus.m_data_in, gid);
        end else begin
          e = ebq[gid].pop_front();
          chk("beat", 64'({bus.m_data_in, bus.m_keep_in, bus.m_last_in}), 64'({e.data, e.keep, e.last}));
        end
      end
      oh = N'(1) << grant_id;
      leak = (((bus.s_ready_insert | bus.s_ready_in) & ~oh) != '0)
          || (!busy && ((bus.s_ready_insert | bus.s_ready_in) != '0 || bus.m_valid_insert || bus.m_valid_in))
          || (bus.m_valid_insert && bus.m_valid_in);
      chk("quiet", 64'(leak), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic bit idle_now();
    for (int s = 0; s < N; s++) begin
      if (hq[s].size() > 0 || bq[s].size() > 0 || ehq[s].size() > 0 || ebq[s].size() > 0) return 1'b0;
    end
    return !busy;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int c;
    c = 0;
    tick();
    while (!idle_now() && c < budget) begin
      tick();
      c++;
    end
    chk({nm, "_idle"}, 64'(idle_now()), 64'd1);
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_pkt_done"}, 64'(pkt_done), 64'd0);
    chk({pfx, "_grant"}, 64'(grant_id), 64'd0);
    chk({pfx, "_mvalid"}, 64'({bus.m_valid_insert, bus.m_valid_in}), 64'd0);
    chk({pfx, "_sready"}, 64'({bus.s_ready_insert, bus.s_ready_in}), 64'd0);
  endtask

  // Called at a falling edge: asserts reset between edges, flushes sources.
  task automatic do_reset(input string pfx);
    #2;
    rst_n = 1'b0;
    for (int s = 0; s < N; s++) begin
      hq[s].delete(); bq[s].delete(); ehq[s].delete(); ebq[s].delete();
    end
    hacc = '0; bacc = '0; exp_pd = 1'b0;
    drive();
    #1;
    chk_quiet({pfx, "_low"});
    @(negedge clk);
    chk_quiet({pfx, "_held"});
    rst_n = 1'b1;
    #1;
    chk_quiet({pfx, "_rel"});
  endtask

  task automatic chk_order(input string nm, input logic [15:0] ord, input int n);
    chk({nm, "_order_len"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk({nm, "_order"}, 64'(got_q[i]), 64'(ord[15-4*i -: 4]));
    end
  endtask

  vec_t tbl[9];

  initial begin
    int pd0;
    tbl[0] = '{1'b0, 4'b1100, 8'd1, 16'h3200, 4'd2};  // rr_ptr=3 after source 2
    tbl[1] = '{1'b1, 4'b1011, 8'd1, 16'h0130, 4'd3};  // from reset
    tbl[2] = '{1'b0, 4'b1111, 8'd2, 16'h0123, 4'd4};
    tbl[3] = '{1'b0, 4'b0110, 8'd1, 16'h1200, 4'd2};
    tbl[4] = '{1'b0, 4'b1000, 8'd1, 16'h3000, 4'd1};
    tbl[5] = '{1'b0, 4'b1001, 8'd3, 16'h0300, 4'd2};  // wrap after source 3
    tbl[6] = '{1'b0, 4'b0101, 8'd2, 16'h0200, 4'd2};
    tbl[7] = '{1'b0, 4'b0011, 8'd1, 16'h0100, 4'd2};
    tbl[8] = '{1'b0, 4'b1011, 8'd1, 16'h3010, 4'd3};

    drive();
    #12;
    chk_quiet("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_quiet("por_rel");

    // Source 2 alone: one idle arbitration cycle, then header, 3 beats.
    pd0 = pd_cnt;
    got_q.delete();
    push_pkt(2, 3, 32'hA1B2C3D4, 4'hF);
    tick();
    chk("t1_arb_mvalid", 64'(bus.m_valid_insert), 64'd0);
    chk("t1_arb_busy", 64'(busy), 64'd0);
    tick();
    chk("t1_hdr_mvalid", 64'(bus.m_valid_insert), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_hdr", 64'(bus.m_header_insert), 64'hA1B2C3D4);
    wait_idle("t1", 100);
    chk("t1_pkt_done_cnt", 64'(pd_cnt - pd0), 64'd1);
    chk_order("t1", 16'h2000, 1);

    // Simultaneous-request arbitration table.
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].rst_first) do_reset("tbl_rst");
      got_q.delete();
      pd0 = pd_cnt;
      for (int s = 0; s < N; s++) begin
        if (tbl[r].mask[s]) push_pkt(s, int'(tbl[r].nbeats), {8'(s), 8'hE0, 8'(tag), 8'h5A}, 4'(4'hF >> s));
      end
      wait_idle("tbl", 300);
      chk_order("tbl", tbl[r].ord, int'(tbl[r].n_ord));
      chk("tbl_pkt_done_cnt", 64'(pd_cnt - pd0), 64'(tbl[r].n_ord));
    end

    // Source 1 payload valid before its header is accepted.
    got_q.delete();
    hold_ins = 1'b1;
    push_pkt(1, 2, 32'h11223344, 4'h3);
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_hdr_mvalid", 64'(bus.m_valid_insert), 64'd1);
      chk("t3_early_valid", 64'(bus.s_valid_in[1]), 64'd1);
      chk("t3_early_ready", 64'(bus.s_ready_in[1]), 64'd0);
      chk("t3_no_fwd", 64'(bus.m_valid_in), 64'd0);
    end
    hold_ins = 1'b0;
    wait_idle("t3", 100);
    chk_order("t3", 16'h1000, 1);

    // 8-beat packet with m_ready_in toggling every cycle.
    got_q.delete();
    pd0 = pd_cnt;
    toggle_in = 1'b1;
    push_pkt(0, 8, 32'h0BADF00D, 4'hF);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (ehq[0].size() == 0 && ebq[0].size() > 0) chk("t4_grant_held", 64'(busy), 64'd1);
      if (idle_now()) break;
    end
    chk("t4_idle", 64'(idle_now()), 64'd1);
    toggle_in = 1'b0;
    chk("t4_pkt_done_cnt", 64'(pd_cnt - pd0), 64'd1);
    chk_order("t4", 16'h0000, 1);

    // Reset while source 3 is mid-packet (beat 2 of 5 pending).
    push_pkt(3, 5, 32'hDEAD0003, 4'hF);
    for (int c = 0; c < 50 && ebq[3].size() != 3; c++) tick();
    chk("t5_reach_beat2", 64'(ebq[3].size()), 64'd3);
    do_reset("t5_rst");
    got_q.delete();
    push_pkt(0, 1, 32'hC0DE0000, 4'hF);
    push_pkt(3, 1, 32'hC0DE0003, 4'hF);
    wait_idle("t5", 100);
    chk_order("t5", 16'h0300, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_header_insert_arbiter.md
Name: axis_header_insert_arbiter

Overview:
Shares one header-insertion datapath between N_SRC independent requesters. Each requester presents a header channel and a payload AXI-Stream channel. The block grants one requester at a time in round-robin order and forwards that requester's header, then its full payload packet, to the single insertion datapath. The grant is held until the payload beat with last is accepted downstream; it sits directly upstream of the insertion datapath.

Parameters:
DATA_WD, 32, payload/header width in bits
DATA_BYTE_WD, DATA_WD/8, keep width in bytes
N_SRC, 4, number of requesters (2..16)
SRC_WD, $clog2(N_SRC), width of grant index

Ports:
clk  in  1  sole clock
rst_n  in  1  reset
s_valid_insert  in  N_SRC  per-source header valid
s_header_insert  in  N_SRC*DATA_WD  per-source header, source i at bits [i*DATA_WD +: DATA_WD]
s_keep_insert  in  N_SRC*DATA_BYTE_WD  per-source header keep
s_ready_insert  out  N_SRC  per-source header ready
s_valid_in  in  N_SRC  per-source payload valid
s_data_in  in  N_SRC*DATA_WD  per-source payload data
s_keep_in  in  N_SRC*DATA_BYTE_WD  per-source payload keep
s_last_in  in  N_SRC  per-source payload last
s_ready_in  out  N_SRC  per-source payload ready
m_valid_insert  out  1  header valid to datapath
m_header_insert  out  DATA_WD  selected header
m_keep_insert  out  DATA_BYTE_WD  selected header keep
m_ready_insert  in  1  datapath header ready
m_valid_in  out  1  payload valid to datapath
m_data_in  out  DATA_WD  selected payload data
m_keep_in  out  DATA_BYTE_WD  selected payload keep
m_last_in  out  1  selected payload last
m_ready_in  in  1  datapath payload ready
grant_id  out  SRC_WD  currently/last granted source
busy  out  1  high in HDR or PAY
pkt_done  out  1  one-cycle pulse when last payload beat accepted

Behaviour:
- Reset asynchronous active-low on rst_n, clock clk. On reset: state=IDLE, rr_ptr=0, grant_id=0, pkt_done=0. Consequently all s_ready_*, m_valid_* and busy are 0.
- States: IDLE, HDR, PAY (2-bit encoding).
- IDLE: if any s_valid_insert bit is set, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_SRC-1, 0, ...). Register it into grant_id and go to HDR. With no request, stay in IDLE. Arbitration costs exactly one cycle; nothing is forwarded in IDLE.
- HDR: m_valid_insert=s_valid_insert[grant_id]. m_header_insert and m_keep_insert are muxed from grant_id. s_ready_insert[grant_id]=m_ready_insert; all other s_ready_insert bits are 0. On m_valid_insert&&m_ready_insert, go to PAY.
- PAY: m_valid_in, m_data_in, m_keep_in and m_last_in are muxed from grant_id. s_ready_in[grant_id]=m_ready_in; all other bits are 0. On m_valid_in&&m_ready_in&&m_last_in: go to IDLE, set rr_ptr=(grant_id+1) mod N_SRC (wraps at N_SRC-1 to 0), and pulse pkt_done for one cycle (registered).
- Forward paths are purely combinational from the registered grant_id and state: zero added latency and no buffering. Ready passes through combinationally; there is no combinational path from s_valid to s_ready.
- Non-granted sources see ready=0 on both channels at all times. Their payload valid asserted early is held off and never dropped.
- The grant is locked for the whole packet. The granted source deasserting valid mid-packet stalls the grant; no timeout.
- grant_id holds its last value in IDLE. busy=(state!=IDLE).
- m_valid_insert=0 outside HDR; m_valid_in=0 outside PAY. Data/keep outputs in those states carry the grant_id mux value; their value is don't-care while the corresponding valid is 0.
- A single-beat packet (last on the first beat) is legal: HDR→PAY→IDLE.
- Reset mid-packet: the FSM returns to IDLE immediately. The partial packet is abandoned; the datapath is reset by the same rst_n.

Decomposition:
- Package axis_hdr_arb_pkg: state encoding constants (ST_IDLE, ST_HDR, ST_PAY) and a function for the round-robin index increment with wrap.
- Sub-module rr_arbiter (purely combinational, N_SRC-parameterised): inputs req vector and rr_ptr; outputs gnt_valid and gnt_idx. The top level holds the FSM, rr_ptr, grant_id and the muxes.

Test Plan:
- Source 2 requests alone, header 0xA1B2C3D4 with keep 0xF, then 3 payload beats with last on the third, m_ready_* held at 1 → grant_id=2; header appears on m_* one cycle after the request; 3 beats pass unchanged; pkt_done pulses once; rr_ptr=3.
- Sources 0, 1 and 3 request simultaneously from reset, each sending 1-beat packets → grant order 0, 1, 3, then rr_ptr=0; no interleaving of beats between sources.
- Source 1 asserts s_valid_in before its header is accepted → s_ready_in[1]=0 until state=PAY; the first forwarded beat equals the first presented beat.
- m_ready_in toggling 1/0 every cycle during an 8-beat packet → all 8 beats are forwarded in order with no duplicates; the grant is not released until last is accepted.
- rst_n pulled low while in PAY with beat 2 of 5 pending → all ready/valid outputs are 0 while low and on release, state=IDLE, and the next request is granted from rr_ptr=0.
- N_SRC=4 with source 3 granted, then sources 3 and 0 requesting → next grant is 0 (wrap), then 3.
